// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared opcode/state encodings and request type for the M-extension issue controller.
package muldiv_pkg;

    localparam int unsigned MD_DATA_SIZE = 32;
    localparam int unsigned MD_TAG_W     = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BUSY  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } muldiv_state_e;

    typedef struct packed {
        muldiv_op_e                opcode;
        logic [MD_DATA_SIZE-1:0]   lop;
        logic [MD_DATA_SIZE-1:0]   rop;
        logic [MD_TAG_W-1:0]       tag;
    } muldiv_req_t;

endpackage

// File: rtl/muldiv_result_cache.sv
// muldiv_result_cache: one-entry store of the last completed MDU operation and its lookup compare.
// Only instantiated when MULDIV_REUSE_EN is defined.
module muldiv_result_cache
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_SIZE = MD_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 fill_en,
    input  logic [2:0]           fill_opcode,
    input  logic [DATA_SIZE-1:0] fill_lop,
    input  logic [DATA_SIZE-1:0] fill_rop,
    input  logic [DATA_SIZE-1:0] fill_result,
    input  logic                 fill_div_by_zero,
    input  logic                 fill_div_overflow,
    input  logic [2:0]           look_opcode,
    input  logic [DATA_SIZE-1:0] look_lop,
    input  logic [DATA_SIZE-1:0] look_rop,
    output logic                 hit,
    output logic [DATA_SIZE-1:0] hit_result,
    output logic                 hit_div_by_zero,
    output logic                 hit_div_overflow
);

    logic                 valid_q, valid_d;
    logic [2:0]           opcode_q, opcode_d;
    logic [DATA_SIZE-1:0] lop_q, lop_d;
    logic [DATA_SIZE-1:0] rop_q, rop_d;
    logic [DATA_SIZE-1:0] result_q, result_d;
    logic                 dz_q, dz_d;
    logic                 ov_q, ov_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            lop_q    <= '0;
            rop_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            lop_q    <= lop_d;
            rop_q    <= rop_d;
            result_q <= result_d;
            dz_q     <= dz_d;
            ov_q     <= ov_d;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        lop_d    = lop_q;
        rop_d    = rop_q;
        result_d = result_q;
        dz_d     = dz_q;
        ov_d     = ov_q;
        if (fill_en) begin
            valid_d  = 1'b1;
            opcode_d = fill_opcode;
            lop_d    = fill_lop;
            rop_d    = fill_rop;
            result_d = fill_result;
            dz_d     = fill_div_by_zero;
            ov_d     = fill_div_overflow;
        end
    end

    always_comb begin
        hit              = valid_q && (look_opcode == opcode_q) &&
                           (look_lop == lop_q) && (look_rop == rop_q);
        hit_result       = result_q;
        hit_div_by_zero  = dz_q;
        hit_div_overflow = ov_q;
    end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: issues one M-extension op at a time to the multi-cycle MDU and returns its result.
// Define MULDIV_REUSE_EN to answer an exact repeat of the last completed op from a one-entry cache.
module muldiv_issue_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_SIZE = MD_DATA_SIZE,
    parameter int unsigned TAG_W     = MD_TAG_W
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_opcode,
    input  logic [DATA_SIZE-1:0] req_lop,
    input  logic [DATA_SIZE-1:0] req_rop,
    input  logic [TAG_W-1:0]     req_tag,
    input  logic                 flush,
    output logic                 mdu_valid,
    output logic [2:0]           mdu_opcode,
    output logic [DATA_SIZE-1:0] mdu_lop,
    output logic [DATA_SIZE-1:0] mdu_rop,
    input  logic [DATA_SIZE-1:0] mdu_result,
    input  logic                 mdu_done,
    input  logic                 mdu_div_by_zero,
    input  logic                 mdu_div_overflow,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_SIZE-1:0] resp_result,
    output logic [TAG_W-1:0]     resp_tag,
    output logic                 resp_div_by_zero,
    output logic                 resp_div_overflow,
    output logic                 busy
);

    typedef struct packed {
        muldiv_op_e           opcode;
        logic [DATA_SIZE-1:0] lop;
        logic [DATA_SIZE-1:0] rop;
        logic [TAG_W-1:0]     tag;
    } req_t;

    muldiv_state_e        state_q, state_d;
    req_t                 req_q, req_d;
    logic [DATA_SIZE-1:0] result_q, result_d;
    logic                 dz_q, dz_d;
    logic                 ov_q, ov_d;
    logic                 accept;
    logic                 cache_hit;
    logic [DATA_SIZE-1:0] cache_result;
    logic                 cache_dz;
    logic                 cache_ov;

`ifdef MULDIV_REUSE_EN
    muldiv_result_cache #(
        .DATA_SIZE (DATA_SIZE)
    ) u_cache (
        .clk               (clk),
        .nrst              (nrst),
        .fill_en           ((state_q == ST_BUSY) && mdu_done),
        .fill_opcode       (req_q.opcode),
        .fill_lop          (req_q.lop),
        .fill_rop          (req_q.rop),
        .fill_result       (mdu_result),
        .fill_div_by_zero  (mdu_div_by_zero),
        .fill_div_overflow (mdu_div_overflow),
        .look_opcode       (req_opcode),
        .look_lop          (req_lop),
        .look_rop          (req_rop),
        .hit               (cache_hit),
        .hit_result        (cache_result),
        .hit_div_by_zero   (cache_dz),
        .hit_div_overflow  (cache_ov)
    );
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
    assign cache_dz     = 1'b0;
    assign cache_ov     = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            result_q <= result_d;
            dz_q     <= dz_d;
            ov_q     <= ov_d;
        end
    end

    always_comb begin
        accept   = req_valid && req_ready;
        state_d  = state_q;
        req_d    = req_q;
        result_d = result_q;
        dz_d     = dz_q;
        ov_d     = ov_q;

        if (accept) begin
            req_d = '{opcode: muldiv_op_e'(req_opcode), lop: req_lop, rop: req_rop, tag: req_tag};
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = cache_hit ? ST_RESP : ST_START;
            end
            ST_START: begin
                state_d = flush ? ST_DRAIN : ST_BUSY;
            end
            ST_BUSY: begin
                if (mdu_done) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_RESP;
                        result_d = mdu_result;
                        dz_d     = mdu_div_by_zero;
                        ov_d     = mdu_div_overflow;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RESP: begin
                // accept already implies resp_ready && !flush here
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (resp_ready) begin
                    if (accept) state_d = cache_hit ? ST_RESP : ST_START;
                    else        state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (mdu_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept && cache_hit) begin
            result_d = cache_result;
            dz_d     = cache_dz;
            ov_d     = cache_ov;
        end
    end

    always_comb begin
        req_ready = ((state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready)) && !flush;
        mdu_valid = (state_q == ST_START);
        resp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
    end

    assign mdu_opcode        = req_q.opcode;
    assign mdu_lop           = req_q.lop;
    assign mdu_rop           = req_q.rop;
    assign resp_result       = result_q;
    assign resp_tag          = req_q.tag;
    assign resp_div_by_zero  = dz_q;
    assign resp_div_overflow = ov_q;

endmodule
